// File: rtl/perf_snapshot_writer.sv
// perf_snapshot_writer
//   Counts up to NUM_EVENTS single-cycle event strobes over a programmable
//   sampling interval. At every interval tick the counters are snapshotted
//   and restarted, then one frame (header + one word per counter) is streamed
//   into the performance analyzer storage as a ring of frame slots.
//
// Ports
//   clk            single clock
//   reset          asynchronous, active-high reset
//   enable         counters and interval timer advance while high
//   clear          synchronous clear of all state, aborts a frame in flight
//   interval       sampling period in cycles (clamped to FRAME_WORDS+1 minimum)
//   event_in       one-cycle event strobes, bit i feeds counter i
//   write          one-cycle write strobe to the analyzer
//   write_address  analyzer word address (drives the analyzer read_address)
//   write_data     frame word
//   busy           frame write in progress
//   frame_count    frames fully written since reset or clear (wraps)
//
// Header word layout (low 32 bits of write_data):
//   [31:24] frame_count[15:8], or overflow mask[15:8] when NUM_EVENTS > 8
//   [23:16] frame_count[7:0]
//   [15:8]  overflow mask[7:0], zero above NUM_EVENTS
//   [7:0]   8'hA5 marker
module perf_snapshot_writer #(
   parameter int NUM_EVENTS = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [31:0]           interval,
   input  logic [NUM_EVENTS-1:0] event_in,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  busy,
   output logic [15:0]           frame_count
);

   localparam int          FRAME_WORDS  = NUM_EVENTS + 1;
   localparam logic [31:0] MIN_INTERVAL = 32'(FRAME_WORDS + 1);
   localparam int          KW           = 5;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;

   logic [31:0]           interval_eff;
   logic [31:0]           timer;
   logic                  tick;

   logic [DATA_WIDTH-1:0] cnt  [NUM_EVENTS];
   logic [DATA_WIDTH-1:0] snap [NUM_EVENTS];
   logic [NUM_EVENTS-1:0] ovf;

   logic [0:0]            state;
   logic [KW-1:0]         k;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] next_base;

   logic [15:0]           mask16;
   logic [7:0]            hdr_top;
   logic [31:0]           hdr32;
   logic [DATA_WIDTH-1:0] header;
   logic [DATA_WIDTH-1:0] snap_word;

   // ------------------------------------------------------------------
   // Interval timer
   // ------------------------------------------------------------------
   always_comb begin
      interval_eff = (interval > MIN_INTERVAL) ? interval : MIN_INTERVAL;
   end

   assign tick = enable && (timer == (interval_eff - 32'd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (clear) begin
         timer <= '0;
      end else if (enable) begin
         timer <= tick ? '0 : timer + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // Event counters, overflow flags and snapshots
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
         ovf <= '0;
      end else if (clear) begin
         for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
         ovf <= '0;
      end else if (tick) begin
         // An event in the tick cycle already belongs to the new period.
         for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            snap[i] <= cnt[i];
            cnt[i]  <= DATA_WIDTH'(event_in[i]);
         end
         ovf <= '0;
      end else if (enable) begin
         for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            if (event_in[i]) begin
               if (&cnt[i]) begin
                  ovf[i] <= 1'b1;
               end else begin
                  cnt[i] <= cnt[i] + DATA_WIDTH'(1);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame word generation
   // ------------------------------------------------------------------
   // The header is registered in the tick cycle itself, so it is built from
   // the live overflow flags, which still hold the closing period's value.
   always_comb begin
      mask16 = '0;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
         mask16[i] = ovf[i];
      end
      hdr_top = (NUM_EVENTS > 8) ? mask16[15:8] : frame_count[15:8];
      hdr32   = {hdr_top, frame_count[7:0], mask16[7:0], 8'hA5};
      header  = DATA_WIDTH'(hdr32);
   end

   // Word k (1..NUM_EVENTS) carries snapshot k-1.
   always_comb begin
      snap_word = '0;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
         if (32'(k) == (i + 32'd1)) begin
            snap_word = snap[i];
         end
      end
   end

   // Advance to the next slot unless the following frame would not fit.
   always_comb begin
      if ((32'(base) + 32'(2 * FRAME_WORDS)) > (32'd1 << ADDR_WIDTH)) begin
         next_base = '0;
      end else begin
         next_base = base + ADDR_WIDTH'(FRAME_WORDS);
      end
   end

   // ------------------------------------------------------------------
   // Write FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         k             <= '0;
         base          <= '0;
         write         <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         busy          <= 1'b0;
         frame_count   <= '0;
      end else if (clear) begin
         state         <= ST_IDLE;
         k             <= '0;
         base          <= '0;
         write         <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         busy          <= 1'b0;
         frame_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               write <= 1'b0;
               busy  <= 1'b0;
               if (tick) begin
                  // Header goes out in the cycle right after the tick.
                  state         <= ST_WRITE;
                  k             <= KW'(1);
                  write         <= 1'b1;
                  busy          <= 1'b1;
                  write_address <= base;
                  write_data    <= header;
               end
            end
            ST_WRITE: begin
               if (k == KW'(FRAME_WORDS)) begin
                  state       <= ST_IDLE;
                  k           <= '0;
                  write       <= 1'b0;
                  busy        <= 1'b0;
                  base        <= next_base;
                  frame_count <= frame_count + 16'd1;
               end else begin
                  write         <= 1'b1;
                  busy          <= 1'b1;
                  write_address <= base + ADDR_WIDTH'(k);
                  write_data    <= snap_word;
                  k             <= k + KW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               write <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perf_snapshot_writer.sv
module tb_perf_snapshot_writer;

   localparam int N  = 8;
   localparam int FW = N + 1;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int SW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          clear;
   logic [31:0]   interval;
   logic [N-1:0]  event_in;
   logic          write;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic          busy;
   logic [15:0]   frame_count;

   // Narrow-counter instance so saturation is reachable in a short run.
   logic          s_enable;
   logic          s_clear;
   logic [31:0]   s_interval;
   logic [N-1:0]  s_event;
   logic          s_write;
   logic [AW-1:0] s_addr;
   logic [SW-1:0] s_data;
   logic          s_busy;
   logic [15:0]   s_fc;

   perf_snapshot_writer #(.NUM_EVENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .interval(interval), .event_in(event_in), .write(write),
      .write_address(write_address), .write_data(write_data),
      .busy(busy), .frame_count(frame_count)
   );

   perf_snapshot_writer #(.NUM_EVENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(SW)) dut_sat (
      .clk(clk), .reset(reset), .enable(s_enable), .clear(s_clear),
      .interval(s_interval), .event_in(s_event), .write(s_write),
      .write_address(s_addr), .write_data(s_data),
      .busy(s_busy), .frame_count(s_fc)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model and scoreboard
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } word_t;

   word_t         exp_q[$];
   logic [31:0]   m_tmr;
   logic [DW-1:0] m_cnt [N];
   logic [N-1:0]  m_ovf;
   logic [AW-1:0] m_base;
   logic [15:0]   m_fc;
   int            m_due;
   int            cyc_n;

   task automatic model_reset();
      m_tmr = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      m_ovf  = '0;
      m_base = '0;
      m_fc   = '0;
      m_due  = -1;
      exp_q.delete();
   endtask

   task automatic sample();
      word_t w;
      logic  exp_w;
      if (m_due >= 0 && cyc_n >= m_due) begin
         m_fc++;
         m_due = -1;
      end
      exp_w = (exp_q.size() > 0);
      check_eq("write", write, exp_w);
      check_eq("busy", busy, exp_w);
      check_eq("frame_count", frame_count, m_fc);
      if (exp_w) begin
         w = exp_q.pop_front();
         check_eq("addr", write_address, w.a);
         check_eq("data", write_data, w.d);
      end
   endtask

   task automatic model_step();
      logic [31:0] eff;
      logic        tk;
      word_t       w;
      eff = (interval > 32'(FW + 1)) ? interval : 32'(FW + 1);
      if (clear) begin
         model_reset();
         return;
      end
      tk = enable && (m_tmr == eff - 32'd1);
      if (tk) begin
         w.a = m_base;
         w.d = {m_fc, m_ovf, 8'hA5};
         exp_q.push_back(w);
         for (int i = 0; i < N; i++) begin
            w.a = m_base + AW'(i + 1);
            w.d = m_cnt[i];
            exp_q.push_back(w);
         end
         m_due = cyc_n + FW + 1;
         if (int'(m_base) + 2 * FW > (1 << AW)) m_base = '0;
         else m_base = m_base + AW'(FW);
         for (int i = 0; i < N; i++) m_cnt[i] = DW'(event_in[i]);
         m_ovf = '0;
      end else if (enable) begin
         for (int i = 0; i < N; i++) begin
            if (event_in[i]) begin
               if (m_cnt[i] == '1) m_ovf[i] = 1'b1;
               else m_cnt[i] = m_cnt[i] + DW'(1);
            end
         end
      end
      if (enable) m_tmr = tk ? '0 : m_tmr + 32'd1;
   endtask

   // One cycle: check this cycle's outputs, then drive inputs for it.
   task automatic cyc(input logic en, input logic clr, input logic [N-1:0] ev);
      @(negedge clk);
      sample();
      enable   = en;
      clear    = clr;
      event_in = ev;
      model_step();
      cyc_n++;
   endtask

   logic [SW-1:0] s_exp [FW];
   int            s_k;
   logic [N-1:0]  ev;

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0; interval = 32'd20; event_in = '0;
      s_enable = 1'b0; s_clear = 1'b0; s_interval = 32'd5000; s_event = '0;
      model_reset();
      cyc_n = 0;

      @(negedge clk);
      check_eq("rst_write", write, 1'b0);
      check_eq("rst_addr", write_address, '0);
      check_eq("rst_data", write_data, '0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_fc", frame_count, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic frame: 5 events on bit 0, 2 on bit 3 in the first period.
      for (int c = 0; c < 32; c++) begin
         ev = '0;
         ev[0] = (c < 5);
         ev[3] = (c < 2);
         cyc(1'b1, 1'b0, ev);
      end
      check_eq("basic_fc", frame_count, 16'd1);

      // Events exactly in tick cycles land in the following frame.
      for (int c = 0; c < 45; c++) begin
         ev = (m_tmr == 32'd19) ? N'(2) : '0;
         cyc(1'b1, 1'b0, ev);
      end

      // Enable dropped during a frame: the frame still completes.
      for (int c = 0; c < 40 && exp_q.size() == 0; c++) cyc(1'b1, 1'b0, N'($urandom));
      for (int c = 0; c < 12; c++) cyc(1'b0, 1'b0, N'($urandom));
      for (int c = 0; c < 30; c++) cyc(1'b1, 1'b0, N'($urandom));

      // Clear while word k=4 is on the bus.
      for (int c = 0; c < 40 && exp_q.size() == 0; c++) cyc(1'b1, 1'b0, N'($urandom));
      for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, N'($urandom));
      cyc(1'b1, 1'b1, '0);
      cyc(1'b1, 1'b0, '0);
      check_eq("clr_addr", write_address, '0);
      check_eq("clr_data", write_data, '0);
      for (int c = 0; c < 45; c++) cyc(1'b1, 1'b0, N'($urandom));

      // Interval clamp (0 -> 10) and ring wrap over 57+ frames.
      interval = 32'd0;
      cyc(1'b1, 1'b1, '0);
      for (int c = 0; c < 585; c++) cyc(1'b1, 1'b0, N'($urandom));
      check_eq("ring_fc", frame_count, 16'd57);

      // Asynchronous reset in the middle of frame 58.
      #2 reset = 1'b1;
      #1;
      check_eq("arst_write", write, 1'b0);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_addr", write_address, '0);
      check_eq("arst_data", write_data, '0);
      check_eq("arst_fc", frame_count, 16'd0);
      model_reset();
      cyc(1'b0, 1'b0, '0);
      reset = 1'b0;
      for (int c = 0; c < 12; c++) cyc(1'b0, 1'b0, '0);

      // Saturation on the 12-bit instance: 4097 events on counter 2.
      for (int i = 0; i < FW; i++) s_exp[i] = '0;
      s_exp[0] = 12'h4A5;
      s_exp[3] = 12'hFFF;
      s_k = 0;
      for (int c = 0; c < 5015; c++) begin
         @(negedge clk);
         if (s_write) begin
            check_eq("sat_busy", s_busy, 1'b1);
            check_eq("sat_addr", s_addr, AW'(s_k));
            check_eq("sat_data", s_data, (s_k < FW) ? s_exp[s_k] : 12'hBAD);
            s_k++;
         end
         s_enable = 1'b1;
         s_event  = (c < 4097) ? N'(4) : '0;
      end
      check_eq("sat_words", s_k, FW);
      check_eq("sat_fc", s_fc, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
